// File: rtl/sha256_block_assembler_if.sv
// Handshake and bus bundle for sha256_block_assembler: the message-word input side and the 512-bit block output side.
// The slave modport is the assembler's view of the bundle; the master modport is the source/sink's view.
interface sha256_block_assembler_if #(
   parameter int NW = 8
);
   logic [31:0]  i_data;
   logic         i_valid;
   logic         i_last;
   logic [5:0]   i_last_bits;
   logic         o_ready;
   logic [511:0] o_data;
   logic [NW-1:0] o_N;
   logic [8:0]   o_bit_miss;
   logic         o_pad2;
   logic         o_final;
   logic         o_valid;
   logic         i_ready;
   logic         o_overflow;

   modport slave (
      input  i_data, i_valid, i_last, i_last_bits, i_ready,
      output o_ready, o_data, o_N, o_bit_miss, o_pad2, o_final, o_valid, o_overflow
   );

   modport master (
      output i_data, i_valid, i_last, i_last_bits, i_ready,
      input  o_ready, o_data, o_N, o_bit_miss, o_pad2, o_final, o_valid, o_overflow
   );
endinterface

// File: rtl/sha256_block_assembler.sv
// Packs 32-bit message words into 512-bit SHA-256 blocks, with sideband for the padding stage.
// Optional macro SHA_BLOCK_ASM_BYTE_SWAP_EN byte-reverses each accepted word before it is stored.
//
// state     | meaning
// COLLECT   | accepting words into the block buffer
// EMIT      | data block presented downstream
// EMIT_PAD2 | zero, length-only second pad block presented downstream
module sha256_block_assembler #(
   parameter int NW = 8
) (
   input logic i_clk,
   input logic i_rst,
   sha256_block_assembler_if.slave bus
);

   typedef enum logic [1:0] {
      COLLECT   = 2'd0,
      EMIT      = 2'd1,
      EMIT_PAD2 = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    wc_q, wc_d;
   logic [511:0]  buf_q, buf_d;
   logic [NW-1:0] cnt_q, cnt_d;
   logic [511:0]  data_q, data_d;
   logic [NW-1:0] n_q, n_d;
   logic [8:0]    miss_q, miss_d;
   logic          pad2_q, pad2_d;
   logic          final_q, final_d;
   logic          last_blk_q, last_blk_d;
   logic          pad2_pend_q, pad2_pend_d;
   logic          ovf_q, ovf_d;

   logic [31:0]   word_in;
   logic [5:0]    eff_bits;
   logic [9:0]    valid_bits;
   logic [9:0]    miss_full;
   logic          ready;
   logic          accept;
   logic          needs_pad2;
   logic [511:0]  block_fill;
   int            slot_idx;

`ifdef SHA_BLOCK_ASM_BYTE_SWAP_EN
   assign word_in = {bus.i_data[7:0], bus.i_data[15:8], bus.i_data[23:16], bus.i_data[31:24]};
`else
   assign word_in = bus.i_data;
`endif

   assign eff_bits   = ((bus.i_last_bits == 6'd0) || (bus.i_last_bits > 6'd32)) ? 6'd32 : bus.i_last_bits;
   assign valid_bits = {1'b0, wc_q, 5'b00000} + {4'b0000, eff_bits};
   assign miss_full  = 10'd512 - valid_bits;
   assign needs_pad2 = (valid_bits >= 10'd448);
   assign ready      = (state_q == COLLECT) && !ovf_q;
   assign accept     = bus.i_valid && ready;
   assign slot_idx   = 511 - 32 * int'(wc_q);

   // Buffer write; the completed block is built from buf_d so the word arriving this cycle is included.
   always_comb begin
      buf_d = buf_q;
      if (accept) begin
         buf_d[slot_idx -: 32] = word_in;
      end
   end

   // Slots past the last written word may still hold a previous block's words.
   always_comb begin
      block_fill = buf_d;
      for (int i = 0; i < 16; i++) begin
         if (4'(i) > wc_q) begin
            block_fill[511 - 32*i -: 32] = 32'h0;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      wc_d        = wc_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      n_d         = n_q;
      miss_d      = miss_q;
      pad2_d      = pad2_q;
      final_d     = final_q;
      last_blk_d  = last_blk_q;
      pad2_pend_d = pad2_pend_q;
      ovf_d       = ovf_q;

      case (state_q)
         COLLECT: begin
            if (accept) begin
               wc_d = wc_q + 4'd1;
               if ((wc_q == 4'd15) || bus.i_last) begin
                  wc_d    = 4'd0;
                  data_d  = block_fill;
                  n_d     = cnt_q;
                  pad2_d  = 1'b0;
                  state_d = EMIT;
                  if (bus.i_last) begin
                     last_blk_d  = 1'b1;
                     pad2_pend_d = needs_pad2;
                     miss_d      = miss_full[8:0];
                     final_d     = !needs_pad2;
                  end else begin
                     last_blk_d  = 1'b0;
                     pad2_pend_d = 1'b0;
                     miss_d      = 9'd0;
                     final_d     = 1'b0;
                  end
               end
            end
         end
         EMIT: begin
            if (bus.i_ready) begin
               if (last_blk_q) begin
                  if (pad2_pend_q) begin
                     data_d  = '0;
                     pad2_d  = 1'b1;
                     final_d = 1'b1;
                     state_d = EMIT_PAD2;
                  end else begin
                     final_d = 1'b0;
                     cnt_d   = NW'(1);
                     state_d = COLLECT;
                  end
               end else if (cnt_q == {NW{1'b1}}) begin
                  ovf_d   = 1'b1;
                  state_d = COLLECT;
               end else begin
                  cnt_d   = cnt_q + NW'(1);
                  state_d = COLLECT;
               end
            end
         end
         EMIT_PAD2: begin
            if (bus.i_ready) begin
               pad2_d  = 1'b0;
               final_d = 1'b0;
               cnt_d   = NW'(1);
               state_d = COLLECT;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= COLLECT;
         wc_q        <= 4'd0;
         buf_q       <= '0;
         cnt_q       <= NW'(1);
         data_q      <= '0;
         n_q         <= NW'(1);
         miss_q      <= 9'd0;
         pad2_q      <= 1'b0;
         final_q     <= 1'b0;
         last_blk_q  <= 1'b0;
         pad2_pend_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wc_q        <= wc_d;
         buf_q       <= buf_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         n_q         <= n_d;
         miss_q      <= miss_d;
         pad2_q      <= pad2_d;
         final_q     <= final_d;
         last_blk_q  <= last_blk_d;
         pad2_pend_q <= pad2_pend_d;
         ovf_q       <= ovf_d;
      end
   end

   assign bus.o_ready    = ready;
   assign bus.o_valid    = (state_q != COLLECT);
   assign bus.o_data     = data_q;
   assign bus.o_N        = n_q;
   assign bus.o_bit_miss = miss_q;
   assign bus.o_pad2     = pad2_q;
   assign bus.o_final    = final_q;
   assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_sha256_block_assembler.sv
// Directed bench for sha256_block_assembler: hand-computed blocks and sideband, backpressure, reset and overflow.
module tb_sha256_block_assembler;
   localparam int NW = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sha256_block_assembler_if #(.NW(NW)) bus ();

   sha256_block_assembler #(.NW(NW)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [511:0]  blk_data;
   logic [NW-1:0] blk_n;
   logic [8:0]    blk_miss;
   logic          blk_final;
   logic          blk_pad2;

   task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] stored(input logic [31:0] w);
`ifdef SHA_BLOCK_ASM_BYTE_SWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   // Expected block: n words base, base+1, ... in slots 0..n-1, remaining slots zero.
   function automatic logic [511:0] mk(input int n, input logic [31:0] base);
      logic [511:0] b;
      b = '0;
      for (int i = 0; i < n; i++) begin
         b[511 - 32*i -: 32] = stored(base + 32'(i));
      end
      return b;
   endfunction

   task automatic send_word(input logic [31:0] w, input logic last, input logic [5:0] lb);
      int t;
      @(negedge clk);
      bus.i_data      = w;
      bus.i_last      = last;
      bus.i_last_bits = lb;
      bus.i_valid     = 1'b1;
      t = 0;
      while (!bus.o_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!bus.o_ready) check("send_timeout", 512'(bus.o_ready), 512'(1));
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      bus.i_last  = 1'b0;
   endtask

   task automatic send_seq(input int n, input logic [31:0] base, input logic last_end, input logic [5:0] lb);
      for (int i = 0; i < n; i++) begin
         send_word(base + 32'(i), last_end && (i == n - 1), lb);
      end
   endtask

   task automatic get_block();
      int t;
      @(negedge clk);
      t = 0;
      while (!bus.o_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!bus.o_valid) check("block_timeout", 512'(bus.o_valid), 512'(1));
      blk_data  = bus.o_data;
      blk_n     = bus.o_N;
      blk_miss  = bus.o_bit_miss;
      blk_final = bus.o_final;
      blk_pad2  = bus.o_pad2;
      bus.i_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.i_ready = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_valid"}, 512'(bus.o_valid), 512'(0));
      check({tag, "_data"}, bus.o_data, 512'(0));
      check({tag, "_n"}, 512'(bus.o_N), 512'(1));
      check({tag, "_miss"}, 512'(bus.o_bit_miss), 512'(0));
      check({tag, "_final"}, 512'(bus.o_final), 512'(0));
      check({tag, "_pad2"}, 512'(bus.o_pad2), 512'(0));
      check({tag, "_ovf"}, 512'(bus.o_overflow), 512'(0));
      check({tag, "_ready"}, 512'(bus.o_ready), 512'(1));
   endtask

   initial begin
      logic [511:0] hold_data;
      rst             = 1'b1;
      bus.i_data      = 32'h0;
      bus.i_valid     = 1'b0;
      bus.i_last      = 1'b0;
      bus.i_last_bits = 6'd0;
      bus.i_ready     = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_vals("rst");
      rst = 1'b0;

      // single-word "abc" message
      send_word(32'h61626380, 1'b1, 6'd24);
      get_block();
      check("abc_data", blk_data, mk(1, 32'h61626380));
      check("abc_n", 512'(blk_n), 512'(1));
      check("abc_miss", 512'(blk_miss), 512'(488));
      check("abc_final", 512'(blk_final), 512'(1));
      check("abc_pad2", 512'(blk_pad2), 512'(0));

      // 16 full words then one 8-bit word
      send_seq(16, 32'hA0000000, 1'b0, 6'd32);
      get_block();
      check("two_b1_data", blk_data, mk(16, 32'hA0000000));
      check("two_b1_n", 512'(blk_n), 512'(1));
      check("two_b1_miss", 512'(blk_miss), 512'(0));
      check("two_b1_final", 512'(blk_final), 512'(0));
      send_word(32'hB1000000, 1'b1, 6'd8);
      get_block();
      check("two_b2_data", blk_data, mk(1, 32'hB1000000));
      check("two_b2_n", 512'(blk_n), 512'(2));
      check("two_b2_miss", 512'(blk_miss), 512'(504));
      check("two_b2_final", 512'(blk_final), 512'(1));

      // 14 words, 448 valid bits: pad2 block follows
      send_seq(14, 32'hC0000000, 1'b1, 6'd32);
      get_block();
      check("p448_data", blk_data, mk(14, 32'hC0000000));
      check("p448_miss", 512'(blk_miss), 512'(64));
      check("p448_final", 512'(blk_final), 512'(0));
      check("p448_pad2", 512'(blk_pad2), 512'(0));
      get_block();
      check("p448_pb_data", blk_data, 512'(0));
      check("p448_pb_pad2", 512'(blk_pad2), 512'(1));
      check("p448_pb_final", 512'(blk_final), 512'(1));
      check("p448_pb_n", 512'(blk_n), 512'(1));
      check("p448_pb_miss", 512'(blk_miss), 512'(64));
      @(negedge clk);
      check("p448_after_pad2", 512'(bus.o_pad2), 512'(0));
      check("p448_after_final", 512'(bus.o_final), 512'(0));

      // 16 words, full last word: 512 valid bits
      send_seq(16, 32'hD0000000, 1'b1, 6'd32);
      get_block();
      check("p512_data", blk_data, mk(16, 32'hD0000000));
      check("p512_miss", 512'(blk_miss), 512'(0));
      check("p512_final", 512'(blk_final), 512'(0));
      get_block();
      check("p512_pb_pad2", 512'(blk_pad2), 512'(1));
      check("p512_pb_n", 512'(blk_n), 512'(1));
      check("p512_pb_miss", 512'(blk_miss), 512'(0));

      // backpressure; last_bits = 0 counts as 32 -> 96 valid bits
      send_seq(3, 32'hE0000000, 1'b1, 6'd0);
      @(negedge clk);
      hold_data = bus.o_data;
      check("bp_data", hold_data, mk(3, 32'hE0000000));
      for (int c = 0; c < 5; c++) begin
         check("bp_valid", 512'(bus.o_valid), 512'(1));
         check("bp_stable", bus.o_data, hold_data);
         check("bp_miss", 512'(bus.o_bit_miss), 512'(416));
         check("bp_ready", 512'(bus.o_ready), 512'(0));
         @(negedge clk);
      end
      bus.i_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.i_ready = 1'b0;
      @(negedge clk);
      check("bp_ready_after", 512'(bus.o_ready), 512'(1));
      check("bp_valid_after", 512'(bus.o_valid), 512'(0));

      // reset mid-block discards partial data
      send_seq(7, 32'hF0000000, 1'b0, 6'd32);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_vals("midrst");
      @(negedge clk);
      rst = 1'b0;
      send_word(32'h12345678, 1'b1, 6'd32);
      get_block();
      check("midrst_data", blk_data, mk(1, 32'h12345678));
      check("midrst_n", 512'(blk_n), 512'(1));
      check("midrst_miss", 512'(blk_miss), 512'(480));

      // block-counter overflow: 255th non-final block
      for (int b = 1; b <= 254; b++) begin
         send_seq(16, 32'(b) << 8, 1'b0, 6'd32);
         get_block();
      end
      check("ovf_pre", 512'(bus.o_overflow), 512'(0));
      send_seq(16, 32'h00FF0000, 1'b0, 6'd32);
      get_block();
      check("ovf_n255", 512'(blk_n), 512'(255));
      @(negedge clk);
      check("ovf_flag", 512'(bus.o_overflow), 512'(1));
      check("ovf_ready", 512'(bus.o_ready), 512'(0));
      check("ovf_valid", 512'(bus.o_valid), 512'(0));
      rst = 1'b1;
      #1;
      check("ovf_clr", 512'(bus.o_overflow), 512'(0));
      check("ovf_ready_clr", 512'(bus.o_ready), 512'(1));
      @(negedge clk);
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sha256_block_assembler.md
Name: sha256_block_assembler

Overview:
- Upstream neighbour of the padding stage: packs a stream of 32-bit message words into 512-bit blocks.
- For each block it emits the block index, the count of missing bits and the second-pad-block flag that the padding stage consumes.
- When the final data block leaves no room for the 64-bit length field, it emits an extra, length-only pad block.
- Valid/ready handshake on both sides; one clock domain.

Parameters:
- NW, 8, width of block index o_N; maximum message is 2^NW-1 blocks.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_data  input  32  message word; first word received lands in bits [511:480].
- i_valid  input  1  i_data is valid.
- i_last  input  1  current word is the final word of the message.
- i_last_bits  input  6  valid MSB-aligned bits in the final word; legal range 1..32; 0 or >32 treated as 32.
- o_ready  output  1  assembler accepts a word this cycle.
- o_data  output  512  assembled block.
- o_N  output  NW  1-based index of the data block o_data belongs to.
- o_bit_miss  output  9  512 minus the valid bits in the block.
- o_pad2  output  1  block is the length-only second pad block.
- o_final  output  1  last block of the message.
- o_valid  output  1  o_data and its sideband are valid.
- i_ready  input  1  downstream accepts the block.
- o_overflow  output  1  sticky flag: message exceeded 2^NW-1 blocks.

Behaviour:
- Reset (async): state COLLECT; word count = 0; block counter = 1; o_data = 0; o_N = 1; o_bit_miss = 0; o_pad2 = 0; o_final = 0; o_valid = 0; o_overflow = 0.
- A word is accepted when i_valid && o_ready. o_ready = 1 only in COLLECT and only while o_overflow = 0.
- Each accepted word is written into slot wc; wc is 0..15 and slot wc occupies bits [511-32*wc -: 32].
- Word-count zero-fill: slots above wc are driven as zero when a block is emitted.
- COLLECT -> EMIT on:
  - the 16th word (wc = 15), or
  - any word with i_last = 1.
- Sideband registered with the block on that transition:
  - o_N = block counter.
  - Non-final block: o_bit_miss = 0; o_final = 0.
  - Final block: valid_bits = 32*wc + eff_last_bits (9/10-bit arithmetic, no truncation); o_bit_miss = 512 - valid_bits; o_final = 1 unless a pad2 block follows.
- EMIT:
  - o_valid = 1; all outputs held stable until i_ready.
  - On acceptance with a final block and valid_bits < 448: clear o_final, reset the block counter to 1, return to COLLECT.
  - On acceptance with a final block and valid_bits >= 448 (including 512): go to EMIT_PAD2.
  - On acceptance of a non-final block: increment the block counter and return to COLLECT.
- Block counter overflow: if the counter is 2^NW-1 and a non-final block is accepted, set o_overflow and stay in COLLECT with o_ready = 0 until reset.
- EMIT_PAD2:
  - o_valid = 1; o_pad2 = 1; o_final = 1; o_data = 0.
  - o_N and o_bit_miss keep the data-block values, so downstream computes the length from them.
  - On acceptance: o_pad2 = 0, o_final = 0, block counter = 1, return to COLLECT.
  - For valid_bits >= 448 the preceding data block is emitted with o_final = 0 and o_pad2 = 0.
- Output latency: o_valid rises the cycle after the completing word is accepted. Minimum gap between blocks is 1 cycle of COLLECT.
- No input is accepted in EMIT or EMIT_PAD2; backpressure is handled through o_ready only.
- i_last is honoured regardless of wc. A 16-word final message with last_bits = 32 has valid_bits = 512.
- Reset asserted mid-block or mid-emit discards all partial data; outputs return to reset values immediately.

Optional Feature:
- SHA_BLOCK_ASM_BYTE_SWAP_EN defined: each accepted i_data is byte-reversed ({b0,b1,b2,b3}) before storage, for little-endian sources.
  - i_last_bits still counts bits from the MSB of the swapped word.
- SHA_BLOCK_ASM_BYTE_SWAP_EN undefined: words are stored unchanged.

Test Plan:
- Single word 0x61626380, i_last = 1, last_bits = 24 -> one block: o_data[511:480] = 0x61626380, rest 0; o_N = 1; o_bit_miss = 488; o_final = 1; o_pad2 = 0.
- 16 full words, then 1 word with last_bits = 8 -> block 1: o_N = 1, o_bit_miss = 0, o_final = 0. Block 2: o_N = 2, o_bit_miss = 504, o_final = 1.
- 14 words, last_bits = 32 (valid_bits = 448) -> data block: o_bit_miss = 64, o_final = 0. Then pad2 block: o_data = 0, o_pad2 = 1, o_final = 1, o_N = 1, o_bit_miss = 64.
- 16 words, last_bits = 32 -> data block with o_bit_miss = 0, then pad2 block with o_N = 1 and o_bit_miss = 0.
- Hold i_ready = 0 for 5 cycles in EMIT -> o_valid stays 1, o_data and sideband stable, o_ready = 0. Accept on cycle 6 -> o_ready = 1 the next cycle.
- Assert i_rst after 7 words -> outputs return to reset values. A new 1-word message with last_bits = 32 then yields o_N = 1, o_bit_miss = 480.
